fmul_pipe: RTL and testbench

- Parametrised, fully pipelined IEEE-754-style floating-point multiplier.
- Next generation of the FMUL unit: generic exponent/mantissa width, valid/ready handshake with backpressure, round-to-nearest-even, special-value handling and exception flags.
- Sits in the VLIW FP execution slot between operand read and writeback.
- Throughput: 1 op/cycle. Fixed latency: 3 cycles.

---
 rtl/fmul_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_fmul_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe.sv
// Pipelined floating-point multiplier: operand capture, unpack/multiply, normalise, round/pack.
// One global enable stalls every stage together when the consumer is not ready.
module fmul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int PW = 2*MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0]     EXP_ONES = {EXP_W{1'b1}};
  localparam logic signed [EW-1:0] BIAS_S   = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW-1:0] EXP_ZERO = {EW{1'b0}};

  typedef enum logic [1:0] {CLS_NUM, CLS_QNAN, CLS_INF, CLS_ZERO} cls_e;

  logic en_s;

  // operand capture stage
  logic                 v0_q;
  logic [EXP_W+MAN_W:0] a_q, b_q;

  // S1 registers
  logic                 v1_q, sign1_q, inv1_q;
  logic signed [EW-1:0] exp1_q;
  logic [PW-1:0]        prod1_q;
  cls_e                 cls1_q;

  // S2 registers
  logic                 v2_q, sign2_q, inv2_q, guard2_q, sticky2_q;
  logic signed [EW-1:0] exp2_q;
  logic [MAN_W-1:0]     frac2_q;
  cls_e                 cls2_q;

  // output registers
  logic                 out_valid_q;
  logic [EXP_W+MAN_W:0] result_q;
  logic [3:0]           flags_q;

  // next-state values
  logic                 sign1_d, inv1_d;
  logic signed [EW-1:0] exp1_d;
  logic [PW-1:0]        prod1_d;
  cls_e                 cls1_d;
  logic signed [EW-1:0] exp2_d;
  logic [MAN_W-1:0]     frac2_d;
  logic                 guard2_d, sticky2_d;
  logic [EXP_W+MAN_W:0] result_d;
  logic [3:0]           flags_d;

  assign en_s      = !out_valid_q || out_ready;
  assign in_ready  = en_s;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // S1: classify operands, multiply significands, sum exponents (subnormals flush to zero)
  always_comb begin
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    ea = a_q[EXP_W+MAN_W-1:MAN_W];
    eb = b_q[EXP_W+MAN_W-1:MAN_W];
    fa = a_q[MAN_W-1:0];
    fb = b_q[MAN_W-1:0];
    a_zero = (ea == {EXP_W{1'b0}});
    b_zero = (eb == {EXP_W{1'b0}});
    a_inf  = (ea == EXP_ONES) && (fa == {MAN_W{1'b0}});
    b_inf  = (eb == EXP_ONES) && (fb == {MAN_W{1'b0}});
    a_nan  = (ea == EXP_ONES) && (fa != {MAN_W{1'b0}});
    b_nan  = (eb == EXP_ONES) && (fb != {MAN_W{1'b0}});
    a_snan = a_nan && !fa[MAN_W-1];
    b_snan = b_nan && !fb[MAN_W-1];
    sign1_d = a_q[EXP_W+MAN_W] ^ b_q[EXP_W+MAN_W];
    prod1_d = {{(MAN_W+1){1'b0}}, 1'b1, fa} * {{(MAN_W+1){1'b0}}, 1'b1, fb};
    exp1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
    inv1_d  = 1'b0;
    if (a_nan || b_nan) begin
      cls1_d = CLS_QNAN;
      inv1_d = a_snan || b_snan;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      cls1_d = CLS_QNAN;
      inv1_d = 1'b1;
    end else if (a_inf || b_inf) begin
      cls1_d = CLS_INF;
    end else if (a_zero || b_zero) begin
      cls1_d = CLS_ZERO;
    end else begin
      cls1_d = CLS_NUM;
    end
  end

  // S2: normalise the [1,4) product and split off fraction, guard and sticky
  always_comb begin
    logic [PW-1:0] norm;
    if (prod1_q[PW-1]) begin
      norm   = prod1_q;
      exp2_d = exp1_q + EW'(1);
    end else begin
      norm   = prod1_q << 1;
      exp2_d = exp1_q;
    end
    frac2_d   = norm[PW-2 -: MAN_W];
    guard2_d  = norm[PW-2-MAN_W];
    sticky2_d = |norm[PW-3-MAN_W:0];
  end

  // S3: round to nearest even, range check, special override and packing
  always_comb begin
    logic                 inc, carry, inexact;
    logic [MAN_W-1:0]     frac_r;
    logic signed [EW-1:0] exp_r;
    inc             = guard2_q && (sticky2_q || frac2_q[0]);
    {carry, frac_r} = {1'b0, frac2_q} + {{MAN_W{1'b0}}, inc};
    exp_r           = exp2_q + {{(EW-1){1'b0}}, carry};
    inexact         = guard2_q || sticky2_q;
    result_d        = {(EXP_W+MAN_W+1){1'b0}};
    flags_d         = 4'b0000;
    case (cls2_q)
      CLS_QNAN: begin
        result_d = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        flags_d  = {inv2_q, 3'b000};
      end
      CLS_INF: begin
        result_d = {sign2_q, EXP_ONES, {MAN_W{1'b0}}};
      end
      CLS_ZERO: begin
        result_d = {sign2_q, {(EXP_W+MAN_W){1'b0}}};
      end
      CLS_NUM: begin
        if (exp_r >= EXP_MAX) begin
          result_d = {sign2_q, EXP_ONES, {MAN_W{1'b0}}};
          flags_d  = 4'b0101;
        end else if (exp_r <= EXP_ZERO) begin
          result_d = {sign2_q, {(EXP_W+MAN_W){1'b0}}};
          flags_d  = 4'b0011;
        end else begin
          result_d = {sign2_q, exp_r[EXP_W-1:0], frac_r};
          flags_d  = {3'b000, inexact};
        end
      end
      default: begin
        result_d = {(EXP_W+MAN_W+1){1'b0}};
        flags_d  = 4'b0000;
      end
    endcase
    if (!v2_q) begin
      result_d = {(EXP_W+MAN_W+1){1'b0}};
      flags_d  = 4'b0000;
    end
  end

  // pipeline registers: all stages advance together on en, valids and outputs cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= {(EXP_W+MAN_W+1){1'b0}};
      flags_q     <= 4'b0000;
    end else if (en_s) begin
      v0_q        <= in_valid;
      a_q         <= a;
      b_q         <= b;
      v1_q        <= v0_q;
      sign1_q     <= sign1_d;
      inv1_q      <= inv1_d;
      exp1_q      <= exp1_d;
      prod1_q     <= prod1_d;
      cls1_q      <= cls1_d;
      v2_q        <= v1_q;
      sign2_q     <= sign1_q;
      inv2_q      <= inv1_q;
      exp2_q      <= exp2_d;
      frac2_q     <= frac2_d;
      guard2_q    <= guard2_d;
      sticky2_q   <= sticky2_d;
      cls2_q      <= cls1_q;
      out_valid_q <= v2_q;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe: single and half precision instances, directed vectors.
module tb_fmul_pipe;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;
  logic        in_valid_h, in_ready_h, out_valid_h, out_ready_h;
  logic [15:0] a_h, b_h, result_h;
  logic [3:0]  flags_h;

  exp_t q32[$];
  exp_t q16[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic        stall_prev = 1'b0;
  logic [31:0] prev_r;
  logic [3:0]  prev_f;

  fmul_pipe dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  fmul_pipe #(.EXP_W(5), .MAN_W(10), .BIAS(15)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_h), .in_ready(in_ready_h),
    .a(a_h), .b(b_h), .out_valid(out_valid_h), .out_ready(out_ready_h),
    .result(result_h), .flags(flags_h)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // single-precision monitor: handshake invariant, stall stability, in-order results
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid) chk("in_ready_vs_stall", {31'b0, in_ready}, {31'b0, out_ready});
      if (stall_prev && out_valid) begin
        chk("stall_result", result, prev_r);
        chk("stall_flags", {28'b0, flags}, {28'b0, prev_f});
      end
      if (out_valid && out_ready) begin
        if (q32.size() == 0) begin
          chk("unexpected_out", result, 32'hXXXX_XXXX);
        end else begin
          e = q32.pop_front();
          chk("result", result, e.r);
          chk("flags", {28'b0, flags}, {28'b0, e.f});
          if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd3);
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_r     = result;
      prev_f     = flags;
    end
  end

  // half-precision monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid_h && out_ready_h) begin
      if (q16.size() == 0) begin
        chk("h_unexpected_out", {16'b0, result_h}, 32'hXXXX_XXXX);
      end else begin
        e = q16.pop_front();
        chk("h_result", {16'b0, result_h}, e.r);
        chk("h_flags", {28'b0, flags_h}, {28'b0, e.f});
        if (e.lat) chk("h_latency", 32'(cyc - e.acc), 32'd3);
      end
    end
  end

  // present one op and wait (bounded) for acceptance; in_valid is left high
  task automatic send32(input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] vr, input logic [3:0] vf, input bit lat);
    exp_t e;
    int   n;
    a = va; b = vb; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n = n + 1;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'b0, in_ready}, 32'd1);
    end else begin
      e.r = vr; e.f = vf; e.acc = cyc + 1; e.lat = lat;
      q32.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic send16(input logic [15:0] va, input logic [15:0] vb,
                        input logic [15:0] vr, input logic [3:0] vf);
    exp_t e;
    int   n;
    a_h = va; b_h = vb; in_valid_h = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready_h && n < 50) begin
      n = n + 1;
      @(negedge clk);
    end
    if (!in_ready_h) begin
      chk("h_accept_timeout", {31'b0, in_ready_h}, 32'd1);
    end else begin
      e.r = {16'b0, vr}; e.f = vf; e.acc = cyc + 1; e.lat = 1'b1;
      q16.push_back(e);
    end
    @(posedge clk); #1;
    in_valid_h = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 200) begin
      n = n + 1;
      @(posedge clk); #1;
    end
    chk("drain_pending", 32'(q32.size() + q16.size()), 32'd0);
  endtask

  logic [31:0] va_t[15] = '{32'h3FC00000, 32'hBF800000, 32'h3F800001, 32'h3FFFFFFF, 32'h7F7FFFFF,
                            32'h00800000, 32'h80800000, 32'h7F800000, 32'h7F800001, 32'h7FC00000,
                            32'hFF800000, 32'h00000000, 32'h80000000, 32'h00000001, 32'h3FFFFFFF};
  logic [31:0] vb_t[15] = '{32'h40000000, 32'h3F800000, 32'h3F800001, 32'h3FFFFFFF, 32'h40000000,
                            32'h00800000, 32'h00800000, 32'h00000000, 32'h3F800000, 32'h3F800000,
                            32'h40000000, 32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h3F800001};
  logic [31:0] vr_t[15] = '{32'h40400000, 32'hBF800000, 32'h3F800002, 32'h407FFFFE, 32'h7F800000,
                            32'h00000000, 32'h80000000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                            32'hFF800000, 32'h7FC00000, 32'h80000000, 32'h00000000, 32'h40000000};
  logic [3:0]  vf_t[15] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0101,
                            4'b0011, 4'b0011, 4'b1000, 4'b1000, 4'b0000,
                            4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0001};

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 32'h0; b = 32'h0;
    in_valid_h = 1'b0; out_ready_h = 1'b1; a_h = 16'h0; b_h = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'b0, flags}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_h_out_valid", {31'b0, out_valid_h}, 32'd0);
    @(posedge clk); #1;

    // isolated ops: values, flags and latency
    for (int i = 0; i < 15; i++) begin
      send32(va_t[i], vb_t[i], vr_t[i], vf_t[i], 1'b1);
      idle(5);
    end
    drain();

    // back-to-back stream with a 5-cycle consumer stall in the middle
    fork
      begin
        for (int i = 0; i < 8; i++) send32(va_t[i], vb_t[i], vr_t[i], vf_t[i], 1'b0);
        idle(1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset with three ops in flight discards them
    for (int i = 0; i < 3; i++) send32(va_t[i], vb_t[i], vr_t[i], vf_t[i], 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_flags", {28'b0, flags}, 32'd0);
    q32.delete();
    @(posedge clk); #1 rst = 1'b0;
    idle(10);
    chk("midrst_no_stale", 32'(q32.size()), 32'd0);

    // half-precision instance
    send16(16'h3E00, 16'h4000, 16'h4200, 4'b0000);
    send16(16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
    send16(16'h3C01, 16'h3C01, 16'h3C02, 4'b0001);
    send16(16'h3C00, 16'hBC00, 16'hBC00, 4'b0000);
    idle(6);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
